multi_bisection_ctrl: RTL and testbench
=======================================

# multi_bisection_ctrl

Time-multiplexed, N-channel bisection search controller for the analog front-end. It drives one current reference per channel and shares a single measurement path, requesting one measurement at a time through a req/ready handshake. Per channel it iterates until one of three conditions ends the search: convergence within tolerance, a stalled plant, or an iteration cap. It sits between the front-end measurement block and the per-channel DAC references.

## Interface
- BUS_WIDTH, 10, width of q and i_ref words (W)
- TOL, 1, convergence when |q_measured − q_desired| ≤ TOL
- N_CH, 4, number of channels
- MAX_ITER, BUS_WIDTH+2, evaluations per channel before timeout
- STALL_CNT, 3, consecutive identical error samples that flag instability

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run permission; low aborts a run
- start  in  1  one-cycle pulse, begins a search on all masked channels
- ch_mask  in  N_CH  channels included in the run, sampled at start
- q_desired  in  N_CH*W  packed targets, channel k at [k*W +: W]
- q_measured  in  W  measurement for meas_ch, valid with meas_ready
- meas_ready  in  1  one-cycle pulse, measurement valid
- meas_req  out  1  level, measurement wanted for meas_ch
- meas_ch  out  clog2(N_CH)  channel under measurement
- i_ref  out  N_CH*W  packed references
- converged  out  N_CH  per-channel flags
- unstable  out  N_CH  per-channel flags
- timeout  out  N_CH  per-channel flags
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run end

## Operation
- Per-channel state: a, b, c (W bits); iter counter; prev_err (W+1 signed); stall counter.
- c = (a+b)>>1, computed with a W+1-bit sum and floor. i_ref[k] = c[k].
- FSM states: IDLE, SCAN, REQ, EVAL, DONE.
- IDLE: on start & enable:
  - per channel, a=0, b=2^W−1, c=2^(W−1)−1.
  - clear iter and all flags; latch ch_mask; ptr=0; go to SCAN.
  - start is ignored when busy.
- SCAN: one channel examined per cycle.
  - If every masked channel is finished (converged|unstable|timeout), or the mask is 0, go to DONE.
  - Otherwise, if ptr is masked and unfinished, go to REQ.
  - Otherwise ptr = ptr+1, wrapping at N_CH.
- REQ: meas_req=1 and meas_ch=ptr, both held until meas_ready. On meas_ready, capture q_measured and go to EVAL. meas_ready outside REQ is ignored.
- EVAL:
  - err = |q_measured − q_desired[ptr]|, signed W+1.
  - iter++.
  - Decision, in priority order:
    - err ≤ TOL: converged.
    - q_desired > q_measured: a=c.
    - q_desired < q_measured: b=c.
  - Stall: if err == prev_err, stall++; otherwise stall=0. When stall reaches STALL_CNT−1, set unstable.
  - If not converged or unstable and iter == MAX_ITER, set timeout.
  - prev_err=err; ptr++; go to SCAN.
  - Flags are sticky until the next start or rst.
- DONE: done=1 for one cycle, then go to IDLE.
- enable low in any non-IDLE state: next state IDLE. meas_req drops, i_ref and flags hold, and done is not pulsed.
- Unmasked channels keep their i_ref and flags untouched during a run.

## Timing
- Reset values:
  - i_ref every channel = 2^(W−1)−1 (511 at W=10).
  - All flags 0; meas_req 0; meas_ch 0; busy 0; done 0.
- busy rises the cycle after start.
- i_ref[k] updates on the clock edge ending EVAL, so it is visible the next cycle.
- One iteration = SCAN (≥1) + REQ (≥1, ends on meas_ready) + EVAL (1).
- A meas_ready coinciding with an enable drop is discarded.
- rst mid-run returns every register to its reset value immediately.

## Structure
- Shared package bisection_pkg holds the FSM state encoding and the clog2 helper/constants.
- Sub-module bisection_channel, instantiated N_CH times, holds a/b/c, iter, prev_err and stall, and is updated only when selected in EVAL. The FSM and handshake live in the top module.

## Test plan
- Reset check: rst pulse → i_ref all 511, flags 0, meas_req 0, busy 0.
- Single-channel convergence: N_CH=2, mask=01, q_des0=300, plant echoes i_ref.
  - i_ref0 sequence is 511, 255, 383, 319, 287, 303, 295, 299.
  - Ends with converged[0]=1, one done pulse, and i_ref1 unchanged at 511.
- Interleave: mask=11, q_des0=300, q_des1=800 → meas_ch alternates 0,1,0,1 until both channels converge.
- Stuck plant: q_measured fixed at 100, q_des0=600 → err 500 repeats. unstable[0]=1 after the third evaluation, and converged stays 0.
- Timeout: MAX_ITER=4, q_des0=700, echo plant → i_ref0 goes 511, 767, 639, 703, 671; timeout[0]=1 after the 4th evaluation.
- Abort: drop enable while in REQ → busy=0 and meas_req=0 next cycle, i_ref holds, no done. A later start restarts from 511.

Source files
------------

// File: rtl/bisection_pkg.sv
// Shared definitions for the multi-channel bisection controller:
// FSM state encoding and width helpers used by the top and channel modules.
package bisection_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_REQ  = 3'd2,
        ST_EVAL = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Channel pointer width, never narrower than one bit.
    function automatic int ptr_width_f(input int n_ch);
        return (n_ch > 1) ? clog2_f(n_ch) : 1;
    endfunction

endpackage

// File: rtl/bisection_channel.sv
// One channel of the bisection search: interval bounds a/b, midpoint c,
// iteration and stall tracking, and the sticky end-of-search flags.
// State changes only on init (run start) or when selected in EVAL.
module bisection_channel
    import bisection_pkg::*;
#(
    parameter int W         = 10,
    parameter int TOL       = 1,
    parameter int MAX_ITER  = 12,
    parameter int STALL_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_i,
    input  logic         eval_i,
    input  logic [W-1:0] q_desired_i,
    input  logic [W-1:0] q_measured_i,
    output logic [W-1:0] c_o,
    output logic         converged_o,
    output logic         unstable_o,
    output logic         timeout_o,
    output logic         finished_o
);

    localparam int ITER_W  = clog2_f(MAX_ITER + 1) + 1;
    localparam int STALL_W = clog2_f(STALL_CNT + 1) + 1;
    localparam logic [W-1:0] C_INIT = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic signed [W:0]  prev_err_q, prev_err_d;
    logic               conv_q, conv_d, unst_q, unst_d, tout_q, tout_d;
    logic signed [W:0]  diff_s, err_s;
    logic [W:0]         sum_s;

    // Next-state: interval update, stall tracking and flag decisions for one evaluation.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        iter_d     = iter_q;
        stall_d    = stall_q;
        prev_err_d = prev_err_q;
        conv_d     = conv_q;
        unst_d     = unst_q;
        tout_d     = tout_q;
        diff_s     = $signed({1'b0, q_measured_i}) - $signed({1'b0, q_desired_i});
        if (diff_s[W] == 1'b1) begin
            err_s = -diff_s;
        end else begin
            err_s = diff_s;
        end
        sum_s = {1'b0, a_q} + {1'b0, b_q};
        if (init_i) begin
            a_d        = '0;
            b_d        = '1;
            c_d        = C_INIT;
            iter_d     = '0;
            stall_d    = '0;
            // All-ones (-1) can never match a magnitude, so the first sample never stalls.
            prev_err_d = '1;
            conv_d     = 1'b0;
            unst_d     = 1'b0;
            tout_d     = 1'b0;
        end else if (eval_i) begin
            iter_d     = iter_q + ITER_W'(1);
            prev_err_d = err_s;
            if (err_s == prev_err_q) begin
                stall_d = stall_q + STALL_W'(1);
            end else begin
                stall_d = '0;
            end
            if (err_s <= $signed((W+1)'(TOL))) begin
                conv_d = 1'b1;
            end else begin
                if (q_desired_i > q_measured_i) begin
                    a_d = c_q;
                end else begin
                    b_d = c_q;
                end
                sum_s = {1'b0, a_d} + {1'b0, b_d};
                c_d   = sum_s[W:1];
                if (stall_d >= STALL_W'(STALL_CNT - 1)) begin
                    unst_d = 1'b1;
                end else if (iter_d == ITER_W'(MAX_ITER)) begin
                    tout_d = 1'b1;
                end else begin
                    tout_d = tout_q;
                end
            end
        end else begin
            a_d = a_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '1;
            c_q        <= C_INIT;
            iter_q     <= '0;
            stall_q    <= '0;
            prev_err_q <= '1;
            conv_q     <= 1'b0;
            unst_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            iter_q     <= iter_d;
            stall_q    <= stall_d;
            prev_err_q <= prev_err_d;
            conv_q     <= conv_d;
            unst_q     <= unst_d;
            tout_q     <= tout_d;
        end
    end

    assign c_o         = c_q;
    assign converged_o = conv_q;
    assign unstable_o  = unst_q;
    assign timeout_o   = tout_q;
    assign finished_o  = conv_q | unst_q | tout_q;

endmodule

// File: rtl/multi_bisection_ctrl.sv
// Time-multiplexed N-channel bisection controller. A single FSM walks the
// masked channels round-robin, requests one measurement at a time over the
// req/ready handshake and hands the captured sample to the selected channel.
module multi_bisection_ctrl
    import bisection_pkg::*;
#(
    parameter int BUS_WIDTH = 10,
    parameter int TOL       = 1,
    parameter int N_CH      = 4,
    parameter int MAX_ITER  = BUS_WIDTH + 2,
    parameter int STALL_CNT = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           start,
    input  logic [N_CH-1:0]                ch_mask,
    input  logic [N_CH*BUS_WIDTH-1:0]      q_desired,
    input  logic [BUS_WIDTH-1:0]           q_measured,
    input  logic                           meas_ready,
    output logic                           meas_req,
    output logic [ptr_width_f(N_CH)-1:0]   meas_ch,
    output logic [N_CH*BUS_WIDTH-1:0]      i_ref,
    output logic [N_CH-1:0]                converged,
    output logic [N_CH-1:0]                unstable,
    output logic [N_CH-1:0]                timeout,
    output logic                           busy,
    output logic                           done
);

    localparam int W     = BUS_WIDTH;
    localparam int PTR_W = ptr_width_f(N_CH);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_inc_s, ch_q;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [W-1:0]       meas_q, meas_d;
    logic               busy_q, req_q, done_q;
    logic [N_CH-1:0]    finished_s, init_s, eval_s;
    logic               all_done_s;

    assign ptr_inc_s  = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign all_done_s = &(~mask_q | finished_s);

    // FSM next-state, channel selection and measurement capture.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        meas_d  = meas_q;
        init_s  = '0;
        eval_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && enable) begin
                    state_d = ST_SCAN;
                    mask_d  = ch_mask;
                    ptr_d   = '0;
                    init_s  = ch_mask;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (all_done_s) begin
                    state_d = ST_DONE;
                end else if (mask_q[ptr_q] && !finished_s[ptr_q]) begin
                    state_d = ST_REQ;
                end else begin
                    ptr_d = ptr_inc_s;
                end
            end
            ST_REQ: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (meas_ready) begin
                    meas_d  = q_measured;
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_EVAL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    eval_s[ptr_q] = 1'b1;
                    ptr_d         = ptr_inc_s;
                    state_d       = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            mask_q  <= '0;
            meas_q  <= '0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            meas_q  <= meas_d;
            busy_q  <= (state_d != ST_IDLE);
            req_q   <= (state_d == ST_REQ);
            done_q  <= (state_d == ST_DONE);
            ch_q    <= ptr_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        bisection_channel #(
            .W         (W),
            .TOL       (TOL),
            .MAX_ITER  (MAX_ITER),
            .STALL_CNT (STALL_CNT)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .init_i       (init_s[k]),
            .eval_i       (eval_s[k]),
            .q_desired_i  (q_desired[k*W +: W]),
            .q_measured_i (meas_q),
            .c_o          (i_ref[k*W +: W]),
            .converged_o  (converged[k]),
            .unstable_o   (unstable[k]),
            .timeout_o    (timeout[k]),
            .finished_o   (finished_s[k])
        );
    end

    assign meas_req = req_q;
    assign meas_ch  = ch_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_multi_bisection_ctrl.sv
// Directed, table-driven bench for multi_bisection_ctrl. dut_a uses the default
// iteration cap, dut_b a cap of 4 for the timeout case; both are 2-channel.
module tb_multi_bisection_ctrl;

    localparam int W = 10;

    logic             clk = 1'b0;
    logic             rst, enable, start_a, start_b, meas_ready;
    logic [1:0]       ch_mask;
    logic [2*W-1:0]   q_desired;
    logic [W-1:0]     q_measured;

    logic             a_req, a_busy, a_done, b_req, b_busy, b_done;
    logic [0:0]       a_ch, b_ch;
    logic [2*W-1:0]   a_iref, b_iref;
    logic [1:0]       a_conv, a_unst, a_tout, b_conv, b_unst, b_tout;

    logic             sel;
    logic             cur_req, cur_busy, cur_done;
    logic [0:0]       cur_ch;
    logic [2*W-1:0]   cur_iref;
    logic [1:0]       cur_conv, cur_unst, cur_tout;

    int total = 0;
    int bad   = 0;
    int log_ch[$];
    int log_ref[$];

    always #5 clk = ~clk;

    multi_bisection_ctrl #(.BUS_WIDTH(W), .N_CH(2)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .start(start_a), .ch_mask(ch_mask),
        .q_desired(q_desired), .q_measured(q_measured), .meas_ready(meas_ready),
        .meas_req(a_req), .meas_ch(a_ch), .i_ref(a_iref), .converged(a_conv),
        .unstable(a_unst), .timeout(a_tout), .busy(a_busy), .done(a_done)
    );

    multi_bisection_ctrl #(.BUS_WIDTH(W), .N_CH(2), .MAX_ITER(4)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .start(start_b), .ch_mask(ch_mask),
        .q_desired(q_desired), .q_measured(q_measured), .meas_ready(meas_ready),
        .meas_req(b_req), .meas_ch(b_ch), .i_ref(b_iref), .converged(b_conv),
        .unstable(b_unst), .timeout(b_tout), .busy(b_busy), .done(b_done)
    );

    // Route the selected DUT's outputs to the shared plant/check logic.
    always_comb begin
        if (sel) begin
            cur_req = b_req; cur_busy = b_busy; cur_done = b_done; cur_ch = b_ch;
            cur_iref = b_iref; cur_conv = b_conv; cur_unst = b_unst; cur_tout = b_tout;
        end else begin
            cur_req = a_req; cur_busy = a_busy; cur_done = a_done; cur_ch = a_ch;
            cur_iref = a_iref; cur_conv = a_conv; cur_unst = a_unst; cur_tout = a_tout;
        end
    end

    typedef struct {
        bit         sel;
        logic [1:0] mask;
        int         des0, des1;
        bit         fixed;
        int         fixval;
        int         evals;
        logic [1:0] conv, unst, tout;
        int         ref0, ref1;
    } vec_t;

    vec_t vecs[7];
    int   seq_conv[8]  = '{511, 255, 383, 319, 287, 303, 295, 299};
    int   seq_tout[4]  = '{511, 767, 639, 703};
    int   seq_ilv[13]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; start_a = 1'b0; start_b = 1'b0; meas_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input bit s, input logic [1:0] m, input int d0, input int d1);
        @(negedge clk);
        sel = s; ch_mask = m; q_desired = {W'(d1), W'(d0)}; enable = 1'b1;
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        check("busy_rise", int'(cur_busy), 1);
    endtask

    // Plant model: answers each request one cycle late, echoing i_ref or a fixed value.
    task automatic serve(input bit fixed, input int fixval, input int budget,
                         output int evals, output int dones);
        int wait_cnt;
        int r;
        evals = 0; dones = 0; wait_cnt = 0;
        log_ch.delete(); log_ref.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cur_done) dones++;
            if (!cur_busy) break;
            if (meas_ready) begin
                meas_ready = 1'b0;
            end else if (cur_req) begin
                if (wait_cnt == 1) begin
                    r = (cur_ch == 1'b1) ? int'(cur_iref[2*W-1:W]) : int'(cur_iref[W-1:0]);
                    q_measured = fixed ? W'(fixval) : W'(r);
                    meas_ready = 1'b1;
                    evals++;
                    log_ch.push_back(int'(cur_ch));
                    log_ref.push_back(r);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
        end
        meas_ready = 1'b0;
        check("run_terminates", int'(cur_busy), 0);
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (cur_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int ev, dn;
        bit ok;
        rst = 1'b1; enable = 1'b0; start_a = 1'b0; start_b = 1'b0; meas_ready = 1'b0;
        ch_mask = '0; q_desired = '0; q_measured = '0; sel = 1'b0;

        //          sel  mask   des0 des1 fix val evals conv   unst   tout   ref0 ref1
        vecs[0] = '{1'b0, 2'b01, 300,   0, 1'b0,  0,  8, 2'b01, 2'b00, 2'b00, 299, 511};
        vecs[1] = '{1'b0, 2'b11, 300, 800, 1'b0,  0, 13, 2'b11, 2'b00, 2'b00, 299, 799};
        vecs[2] = '{1'b0, 2'b01, 600,   0, 1'b1,100,  3, 2'b00, 2'b01, 2'b00, 959, 511};
        vecs[3] = '{1'b1, 2'b01, 700,   0, 1'b0,  0,  4, 2'b00, 2'b00, 2'b01, 671, 511};
        vecs[4] = '{1'b0, 2'b00, 300, 800, 1'b0,  0,  0, 2'b00, 2'b00, 2'b00, 511, 511};
        vecs[5] = '{1'b0, 2'b10,   0, 511, 1'b0,  0,  1, 2'b10, 2'b00, 2'b00, 511, 511};
        vecs[6] = '{1'b0, 2'b10,   0, 800, 1'b0,  0,  5, 2'b10, 2'b00, 2'b00, 511, 799};

        // Reset state, sampled while rst is held.
        repeat (2) @(negedge clk);
        check("rst_iref0", int'(a_iref[W-1:0]), 511);
        check("rst_iref1", int'(a_iref[2*W-1:W]), 511);
        check("rst_flags", int'({a_conv, a_unst, a_tout}), 0);
        check("rst_req", int'(a_req), 0);
        check("rst_ch", int'(a_ch), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_b_iref", int'(b_iref), 511 * 1024 + 511);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            start_run(vecs[i].sel, vecs[i].mask, vecs[i].des0, vecs[i].des1);
            serve(vecs[i].fixed, vecs[i].fixval, 400, ev, dn);
            check($sformatf("v%0d_evals", i), ev, vecs[i].evals);
            check($sformatf("v%0d_done", i), dn, 1);
            check($sformatf("v%0d_conv", i), int'(cur_conv), int'(vecs[i].conv));
            check($sformatf("v%0d_unst", i), int'(cur_unst), int'(vecs[i].unst));
            check($sformatf("v%0d_tout", i), int'(cur_tout), int'(vecs[i].tout));
            check($sformatf("v%0d_ref0", i), int'(cur_iref[W-1:0]), vecs[i].ref0);
            check($sformatf("v%0d_ref1", i), int'(cur_iref[2*W-1:W]), vecs[i].ref1);
            if (i == 0) begin
                for (int j = 0; j < 8 && j < log_ref.size(); j++)
                    check($sformatf("conv_seq%0d", j), log_ref[j], seq_conv[j]);
            end else if (i == 1) begin
                for (int j = 0; j < 13 && j < log_ch.size(); j++)
                    check($sformatf("ilv_ch%0d", j), log_ch[j], seq_ilv[j]);
            end else if (i == 3) begin
                for (int j = 0; j < 4 && j < log_ref.size(); j++)
                    check($sformatf("tout_seq%0d", j), log_ref[j], seq_tout[j]);
            end
        end

        // Abort in REQ with a coincident (discarded) measurement that would converge.
        do_reset();
        start_run(1'b0, 2'b01, 300, 0);
        wait_req(50, ok);
        check("abort_req1", int'(ok), 1);
        @(negedge clk);
        q_measured = W'(511); meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        wait_req(50, ok);
        check("abort_req2", int'(ok), 1);
        check("abort_ref_pre", int'(a_iref[W-1:0]), 255);
        enable = 1'b0; q_measured = W'(300); meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        check("abort_busy", int'(a_busy), 0);
        check("abort_req", int'(a_req), 0);
        check("abort_ref_hold", int'(a_iref[W-1:0]), 255);
        check("abort_conv", int'(a_conv), 0);
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            if (a_done) dn++;
            @(negedge clk);
        end
        check("abort_no_done", dn, 0);
        start_run(1'b0, 2'b01, 300, 0);
        check("restart_ref", int'(a_iref[W-1:0]), 511);
        serve(1'b0, 0, 400, ev, dn);
        check("restart_evals", ev, 8);
        check("restart_conv", int'(a_conv), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
